// File: rtl/fxmem_responder.sv
// ============================================================================
// Module      : fxmem_responder
// Description : Word-addressed 16-bit memory target with a grant handshake,
//               programmable wait states, range errors and a host preload port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fxmem_responder #(
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_STATES = 1,
  parameter logic [15:0] ERR_DATA    = 16'hFFFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sel_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [15:0] dat_o,
  output logic        ack_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic [15:0] dat_i,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [15:0] ld_data,
  output logic        ld_busy,
  output logic        err_o,
  output logic [15:0] acc_cnt
);

  localparam int          ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_W   = 32'(DEPTH);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q;
  logic        ack_q;
  logic        cyc_q;
  logic        stb_q;
  logic        busy_q;
  logic        err_q;
  logic [15:0] rdata_q;
  logic [15:0] acc_cnt_q;
  logic [3:0]  wait_q;
  logic [31:0] addr_q;
  logic        we_q;
  logic [15:0] wdata_q;
  logic [15:0] ram_q [DEPTH];

  logic              w_ld_in_range;
  logic              w_addr_in_range;
  logic              w_wait_done;
  logic              w_ram_we;
  logic [ADDR_W-1:0] w_ram_waddr;
  logic [15:0]       w_ram_wdata;

  // Full 32-bit compares: upper address bits never alias into the array.
  assign w_ld_in_range   = (ld_addr < DEPTH_W);
  assign w_addr_in_range = (addr_q < DEPTH_W);
  assign w_wait_done     = (wait_q == 4'd0);

  // Reset suppresses the commit so an aborted write never lands in RAM.
  assign w_ram_we = !rst_i &&
                    (((state_q == S_IDLE) && ld_we && w_ld_in_range) ||
                     ((state_q == S_WAIT) && w_wait_done && !we_q && w_addr_in_range));
  assign w_ram_waddr = (state_q == S_IDLE) ? ld_addr[ADDR_W-1:0] : addr_q[ADDR_W-1:0];
  assign w_ram_wdata = (state_q == S_IDLE) ? ld_data : wdata_q;

  always_ff @(posedge clk_i) begin
    if (w_ram_we) begin
      ram_q[w_ram_waddr] <= w_ram_wdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      ack_q     <= 1'b0;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= 16'h0000;
      acc_cnt_q <= 16'h0000;
      wait_q    <= 4'd0;
      addr_q    <= 32'h0;
      we_q      <= 1'b1;
      wdata_q   <= 16'h0000;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!ld_we && !sel_i) begin
            ack_q   <= 1'b1;
            state_q <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (sel_i && stb_i) begin
            addr_q  <= addr_i;
            we_q    <= we_i;
            wdata_q <= dat_o;
            ack_q   <= 1'b0;
            cyc_q   <= 1'b1;
            busy_q  <= 1'b1;
            wait_q  <= WAIT_INIT;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_wait_done) begin
            if (we_q) begin
              rdata_q <= w_addr_in_range ? ram_q[addr_q[ADDR_W-1:0]] : ERR_DATA;
            end
            if (!w_addr_in_range) begin
              err_q <= 1'b1;
            end
            stb_q     <= 1'b1;
            acc_cnt_q <= acc_cnt_q + 16'd1;
            state_q   <= S_DONE;
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        S_DONE: begin
          // Writes may also release on we_i returning high; reads need stb_i low.
          if (!stb_i || (!we_q && we_i)) begin
            stb_q   <= 1'b0;
            cyc_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ack_o   = ack_q;
  assign cyc_o   = cyc_q;
  assign stb_o   = stb_q;
  assign dat_i   = rdata_q;
  assign ld_busy = busy_q;
  assign err_o   = err_q;
  assign acc_cnt = acc_cnt_q;

endmodule

`default_nettype wire
